// File: rtl/tpu_ram_streamer.sv
// -----------------------------------------------------------------------------
// tpu_ram_streamer
//
// Wishbone classic read master that fetches 32-bit operand words from the TPU
// DFFRAM and streams them little-endian, one byte per valid/ready handshake,
// into the systolic-array operand input.
//
// Optional feature macro: STREAMER_TIMEOUT_EN
//   defined   : FETCH aborts after TIMEOUT_CYCLES cycles without ack, sets the
//               sticky err_o and finishes the transfer.
//   undefined : FETCH waits for ack indefinitely; err_o is tied low.
//
// Ports
//   wb_clk_i, wb_rst_n_i   clock, asynchronous active-low reset
//   start_i                one-cycle start request (ignored while busy)
//   word_off_i, word_cnt_i first word index / word count, sampled on start
//   busy_o, done_o, err_o  transfer status
//   wbm_*                  Wishbone classic master (read-only)
//   op_data_o/op_valid_o/op_ready_i/op_last_o  operand byte stream
// -----------------------------------------------------------------------------
module tpu_ram_streamer #(
    parameter logic [31:0] RAM_BASE       = 32'h3000_0200,
    parameter int unsigned ADDR_WORDS     = 256,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        start_i,
    input  logic [7:0]  word_off_i,
    input  logic [8:0]  word_cnt_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic [7:0]  op_data_o,
    output logic        op_valid_o,
    input  logic        op_ready_i,
    output logic        op_last_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_EMIT  = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    // Word index wraps modulo the RAM depth (power of two).
    localparam logic [7:0] IDX_MASK = 8'(ADDR_WORDS - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [8:0]  rem_q, rem_d;
    logic [31:0] buf_q, buf_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic        err_q, err_d;

`ifdef STREAMER_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_hit;

    // Hit on the TIMEOUT_CYCLES-th consecutive FETCH cycle without ack.
    assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        buf_d   = buf_q;
        bcnt_d  = bcnt_q;
        err_d   = err_q;
`ifdef STREAMER_TIMEOUT_EN
        tmo_d   = (state_q == S_FETCH && !wbm_ack_i) ? tmo_q + TW'(1) : '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    idx_d   = word_off_i & IDX_MASK;
                    rem_d   = word_cnt_i;
                    err_d   = 1'b0;
                    state_d = (word_cnt_i == 9'd0) ? S_FIN : S_FETCH;
                end
            end
            S_FETCH: begin
                if (wbm_ack_i) begin
                    buf_d   = wbm_dat_i;
                    bcnt_d  = 2'd0;
                    state_d = S_EMIT;
                end
`ifdef STREAMER_TIMEOUT_EN
                else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end
`endif
            end
            S_EMIT: begin
                // op_valid_o is high throughout EMIT, so ready alone marks a handshake.
                if (op_ready_i) begin
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        idx_d   = (idx_q + 8'd1) & IDX_MASK;
                        rem_d   = rem_q - 9'd1;
                        state_d = (rem_q == 9'd1) ? S_FIN : S_FETCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            rem_q   <= '0;
            buf_q   <= '0;
            bcnt_q  <= '0;
            err_q   <= 1'b0;
`ifdef STREAMER_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            buf_q   <= buf_d;
            bcnt_q  <= bcnt_d;
            err_q   <= err_d;
`ifdef STREAMER_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    // Outputs decode the registered state only, so an asynchronous reset
    // clears them without waiting for a clock edge.
    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = (state_q == S_FIN);
`ifdef STREAMER_TIMEOUT_EN
    assign err_o      = err_q;
`else
    assign err_o      = 1'b0;
`endif
    assign wbm_cyc_o  = (state_q == S_FETCH);
    assign wbm_stb_o  = (state_q == S_FETCH);
    assign wbm_we_o   = 1'b0;
    assign wbm_sel_o  = 4'hF;
    assign wbm_adr_o  = (state_q == S_FETCH) ? (RAM_BASE + {22'd0, idx_q, 2'b00}) : '0;
    assign op_valid_o = (state_q == S_EMIT);
    assign op_data_o  = (state_q == S_EMIT) ? buf_q[{bcnt_q, 3'b000} +: 8] : '0;
    assign op_last_o  = op_valid_o && (rem_q == 9'd1) && (bcnt_q == 2'd3);

endmodule

// File: tb/tb_tpu_ram_streamer.sv
// -----------------------------------------------------------------------------
// tb_tpu_ram_streamer
//
// Self-checking bench for tpu_ram_streamer: a behavioural Wishbone RAM slave,
// a scoreboard of expected addresses and bytes, and directed stream scenarios.
// The timeout scenario runs only when STREAMER_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_tpu_ram_streamer;

    localparam logic [31:0] BASE = 32'h3000_0200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  off = '0;
    logic [8:0]  cnt = '0;
    logic        busy, done, err;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat = '0;
    logic        ack = 1'b0;
    logic [7:0]  op_data;
    logic        op_valid;
    logic        op_ready = 1'b1;
    logic        op_last;

    typedef struct packed { logic [7:0] d; logic l; } exp_t;

    logic [31:0] mem [256];
    exp_t        exp_q [$];
    logic [31:0] adr_q [$];
    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    int          hs_cnt = 0;
    int          cyc_rise = 0;
    int          lat = 0;
    logic        ack_en = 1'b1;
    int          wait_cnt = 0;

    tpu_ram_streamer #(
        .RAM_BASE      (BASE),
        .ADDR_WORDS    (256),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .start_i    (start),
        .word_off_i (off),
        .word_cnt_i (cnt),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .wbm_cyc_o  (cyc),
        .wbm_stb_o  (stb),
        .wbm_we_o   (we),
        .wbm_sel_o  (sel),
        .wbm_adr_o  (adr),
        .wbm_dat_i  (dat),
        .wbm_ack_i  (ack),
        .op_data_o  (op_data),
        .op_valid_o (op_valid),
        .op_ready_i (op_ready),
        .op_last_o  (op_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Behavioural RAM slave: single-cycle ack after `lat` wait cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack      <= 1'b0;
            wait_cnt <= 0;
        end else if (ack) begin
            ack <= 1'b0;
        end else if (cyc && stb && ack_en) begin
            if (wait_cnt >= lat) begin
                logic [31:0] a;
                a = adr - BASE;
                ack      <= 1'b1;
                dat      <= mem[a[9:2]];
                wait_cnt <= 0;
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end
    end

    // Output monitor / scoreboard consumer.
    logic       prev_cyc = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_cyc   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (cyc && !prev_cyc) begin
                cyc_rise++;
                if (adr_q.size() == 0) chk("extra_fetch", 1, 0);
                else chk("fetch_adr", adr, adr_q.pop_front());
            end
            if (prev_stall) begin
                chk("stall_valid", {31'd0, op_valid}, 1);
                chk("stall_hold", {24'd0, op_data}, {24'd0, prev_data});
            end
            if (op_valid && op_ready) begin
                exp_t e;
                hs_cnt++;
                if (exp_q.size() == 0) chk("extra_byte", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("byte", {24'd0, op_data}, {24'd0, e.d});
                    chk("last", {31'd0, op_last}, {31'd0, e.l});
                end
            end
            if (done) done_cnt++;
            prev_cyc   = cyc;
            prev_stall = op_valid && !op_ready;
            prev_data  = op_data;
        end
    end

    task automatic push_exp(input int o, input int c);
        for (int w = 0; w < c; w++) begin
            logic [7:0]  i;
            logic [31:0] word;
            i    = 8'((o + w) % 256);
            word = mem[i];
            adr_q.push_back(BASE + {22'd0, i, 2'b00});
            for (int b = 0; b < 4; b++) begin
                exp_t e;
                e.d = word[b*8 +: 8];
                e.l = (w == c - 1) && (b == 3);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic do_start(input logic [7:0] o, input logic [8:0] c);
        @(posedge clk) #1;
        start = 1'b1; off = o; cnt = c;
        @(posedge clk) #1;
        start = 1'b0; off = 8'hA5; cnt = 9'h1A5;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk(tag, 0, 1);
        @(negedge clk);
    endtask

    initial begin
        int d0, r0, h0, n;
        logic [31:0] wv;
        for (int i = 0; i < 256; i++) mem[i] = 32'h1F2E_3D4C ^ (i * 32'h0101_0107);
        mem[5] = 32'hDDCC_BBAA;

        // Reset state.
        #2;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_cyc", {30'd0, cyc, stb}, 0);
        chk("rst_adr", adr, 0);
        chk("rst_op", {22'd0, op_valid, op_last, op_data}, 0);
        chk("rst_sel_we", {27'd0, sel, we}, 32'h1E);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single word, zero-latency ready: exact cycle-level timing.
        lat = 0;
        push_exp(5, 1);
        do_start(8'd5, 9'd1);
        @(negedge clk);
        chk("t1_busy_c1", {31'd0, busy}, 1);
        chk("t1_cyc_c1", {30'd0, cyc, stb}, 3);
        chk("t1_adr", adr, 32'h3000_0214);
        n = 0;
        while (!op_valid && n < 20) begin @(negedge clk); n++; end
        chk("t1_cyc_low_on_valid", {31'd0, cyc}, 0);
        wv = 32'hDDCC_BBAA;
        for (int k = 0; k < 4; k++) begin
            chk("t1_valid", {31'd0, op_valid}, 1);
            chk("t1_data", {24'd0, op_data}, {24'd0, wv[k*8 +: 8]});
            chk("t1_last", {31'd0, op_last}, (k == 3) ? 1 : 0);
            @(negedge clk);
        end
        chk("t1_done", {31'd0, done}, 1);
        chk("t1_busy_fin", {31'd0, busy}, 1);
        @(negedge clk);
        chk("t1_done_pulse", {31'd0, done}, 0);
        chk("t1_busy_low", {31'd0, busy}, 0);

        // Zero count: done at cycle 1, no bus activity.
        r0 = cyc_rise;
        do_start(8'd7, 9'd0);
        @(negedge clk);
        chk("t0_done", {31'd0, done}, 1);
        chk("t0_cyc", {31'd0, cyc}, 0);
        chk("t0_valid", {31'd0, op_valid}, 0);
        @(negedge clk);
        chk("t0_idle", {30'd0, busy, done}, 0);
        chk("t0_no_fetch", cyc_rise - r0, 0);

        // Index wrap 255 -> 0.
        lat = 1;
        r0 = cyc_rise; h0 = hs_cnt;
        push_exp(255, 2);
        do_start(8'd255, 9'd2);
        wait_done("t2_done_timeout", 200);
        chk("t2_fetches", cyc_rise - r0, 2);
        chk("t2_bytes", hs_cnt - h0, 8);

        // Random ready stalls over 3 words.
        lat = 2;
        d0 = done_cnt; h0 = hs_cnt;
        push_exp(10, 3);
        do_start(8'd10, 9'd3);
        n = 0;
        while (done_cnt == d0 && n < 600) begin
            @(posedge clk) #1 op_ready = 1'($urandom_range(0, 1));
            n++;
        end
        op_ready = 1'b1;
        chk("t3_done", done_cnt - d0, 1);
        chk("t3_bytes", hs_cnt - h0, 12);
        @(negedge clk);

        // Start pulsed mid-stream is ignored.
        lat = 1;
        d0 = done_cnt; r0 = cyc_rise;
        push_exp(20, 2);
        do_start(8'd20, 9'd2);
        repeat (4) @(posedge clk);
        do_start(8'd40, 9'd5);
        wait_done("t4_done_timeout", 200);
        repeat (10) @(negedge clk);
        chk("t4_done_once", done_cnt - d0, 1);
        chk("t4_fetches", cyc_rise - r0, 2);
        chk("t4_idle", {31'd0, busy}, 0);

        // Reset while cyc is high during a 4-word stream.
        lat = 3;
        d0 = done_cnt; h0 = hs_cnt;
        push_exp(50, 4);
        do_start(8'd50, 9'd4);
        n = 0;
        while (!(cyc && hs_cnt - h0 >= 4) && n < 200) begin @(negedge clk); n++; end
        chk("t5_reached_cyc", {31'd0, cyc}, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_rst_status", {29'd0, busy, done, err}, 0);
        chk("t5_rst_bus", {30'd0, cyc, stb}, 0);
        chk("t5_rst_adr", adr, 0);
        chk("t5_rst_op", {22'd0, op_valid, op_last, op_data}, 0);
        exp_q.delete();
        adr_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        chk("t5_no_done", done_cnt - d0, 0);
        h0 = hs_cnt;
        push_exp(60, 1);
        do_start(8'd60, 9'd1);
        wait_done("t5_done_timeout", 200);
        chk("t5_bytes", hs_cnt - h0, 4);

`ifdef STREAMER_TIMEOUT_EN
        // Ack never returned: abort after 16 cycles with err.
        ack_en = 1'b0;
        d0 = done_cnt; h0 = hs_cnt;
        adr_q.push_back(BASE);
        do_start(8'd0, 9'd2);
        n = 0;
        while (!cyc && n < 5) begin @(negedge clk); n++; end
        n = 0;
        while (cyc && n < 100) begin @(negedge clk); n++; end
        chk("t6_cyc_cycles", n, 16);
        chk("t6_done", {31'd0, done}, 1);
        chk("t6_err", {31'd0, err}, 1);
        @(negedge clk);
        chk("t6_err_sticky", {31'd0, err}, 1);
        chk("t6_no_bytes", hs_cnt - h0, 0);
        ack_en = 1'b1;
        do_start(8'd0, 9'd0);
        @(negedge clk);
        chk("t6_err_clr", {31'd0, err}, 0);
        @(negedge clk);
`else
        chk("err_tied_low", {31'd0, err}, 0);
`endif

        chk("left_bytes", exp_q.size(), 0);
        chk("left_adrs", adr_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
